// File: rtl/mem_responder.sv
// Single-port-per-side RAM responder with a small MMIO page (timer, compare, IRQ status).
// Optional timer/IRQ page enabled by defining MEM_RESPONDER_TIMER_IRQ_EN.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ia,
    output logic [31:0] id,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        wr,
    input  logic [15:0] wr_mask,
    output logic [31:0] mrd,
    output logic        irq,
    output logic        bus_err
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic          i_ram_hit;
    logic          d_ram_hit;
    logic          d_mmio_hit;
    logic [1:0]    reg_off;
    logic [31:0]   mmio_rdata;

    logic [31:0] id_q, id_d;
    logic [31:0] mrd_q, mrd_d;
    logic        bus_err_q, bus_err_d;

    logic unused_ok;
    assign unused_ok = ^{ia[1:0], addr_in[1:0], wr_mask[15:4]};

    assign i_idx      = ia[AW+1:2];
    assign d_idx      = addr_in[AW+1:2];
    assign i_ram_hit  = (ia[31:AW+2] == '0);
    assign d_ram_hit  = (addr_in[31:AW+2] == '0);
    assign d_mmio_hit = !d_ram_hit && (addr_in[31:4] == MMIO_BASE[31:4]);
    assign reg_off    = addr_in[3:2];

`ifdef MEM_RESPONDER_TIMER_IRQ_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q + 32'd1;
        cmp_d  = cmp_q;
        pend_d = pend_q;
        if (wr && d_mmio_hit && reg_off == 2'd1) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) cmp_d[8*i +: 8] = data_in[8*i +: 8];
            end
        end
        if (wr && d_mmio_hit && reg_off == 2'd2 && wr_mask[0] && data_in[0]) begin
            pend_d = 1'b0;
        end
        // A match in the same cycle as a clear must leave the interrupt pending.
        if (cnt_q == cmp_q && cmp_q != '0) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            cmp_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        case (reg_off)
            2'd0:    mmio_rdata = cnt_q;
            2'd1:    mmio_rdata = cmp_q;
            2'd2:    mmio_rdata = {31'd0, pend_q};
            default: mmio_rdata = '0;
        endcase
    end

    assign irq = pend_q;
`else
    assign mmio_rdata = '0;
    assign irq        = 1'b0;
`endif

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        id_d      = i_ram_hit ? mem[i_idx] : NOP;
        mrd_d     = mrd_q;
        bus_err_d = bus_err_q | (!d_ram_hit && !d_mmio_hit);
        if (!wr) begin
            if (d_ram_hit)       mrd_d = mem[d_idx];
            else if (d_mmio_hit) mrd_d = mmio_rdata;
            else                 mrd_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q      <= '0;
            mrd_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            id_q      <= id_d;
            mrd_q     <= mrd_d;
            bus_err_q <= bus_err_d;
        end
    end

    // NOTE: the RAM array is deliberately not reset; reset only blocks the write enable.
    always_ff @(posedge clk) begin
        if (!reset && wr && d_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[d_idx][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    assign id      = id_q;
    assign mrd     = mrd_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, hand sequences and random traffic
// against a word-array reference model. Timer checks follow MEM_RESPONDER_TIMER_IRQ_EN.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ia = '0;
    logic [31:0] id;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic        wr = 1'b0;
    logic [15:0] wr_mask = '0;
    logic [31:0] mrd;
    logic        irq;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_mrd;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] mask;
        logic [31:0] ia;
        logic [31:0] exp_mrd;
        logic [31:0] exp_id;
    } vec_t;

    vec_t tbl [11];

    mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .ia      (ia),
        .id      (id),
        .addr_in (addr_in),
        .data_in (data_in),
        .wr      (wr),
        .wr_mask (wr_mask),
        .mrd     (mrd),
        .irq     (irq),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [15:0] m, input logic [31:0] fa);
        wr      = w;
        addr_in = a;
        data_in = d;
        wr_mask = m;
        ia      = fa;
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'hC0DE_0000 | i;
    endfunction

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        if (a < DEPTH * 4) return model_mem[a / 4];
        return NOP;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [15:0] m);
        if (a < DEPTH * 4) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) model_mem[a / 4][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_ram_addr();
        int w;
        w = $urandom_range(0, 64);
        if (w == 64) w = DEPTH - 1;
        return 32'(w * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        tbl[0]  = '{1'b0, 32'h10,       32'h0,          16'h000F, 32'h10,       32'hC0DE0004, 32'hC0DE0004};
        tbl[1]  = '{1'b1, 32'h10,       32'hDEADBEEF,   16'h000F, 32'h10,       32'hC0DE0004, 32'hC0DE0004};
        tbl[2]  = '{1'b0, 32'h10,       32'h0,          16'h0000, 32'h10,       32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 32'h10,       32'h000000AA,   16'h0001, 32'h13,       32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h12,       32'h0,          16'h0000, 32'h14,       32'hDEADBEAA, 32'hC0DE0005};
        tbl[5]  = '{1'b1, 32'h14,       32'h11223344,   16'hF00A, 32'h1000,     32'hDEADBEAA, NOP};
        tbl[6]  = '{1'b0, 32'h14,       32'h0,          16'h0000, 32'hFFC,      32'h11DE3305, 32'hC0DE03FF};
        tbl[7]  = '{1'b1, 32'h18,       32'hFFFFFFFF,   16'hFFF0, 32'h18,       32'h11DE3305, 32'hC0DE0006};
        tbl[8]  = '{1'b0, 32'h18,       32'h0,          16'h0000, 32'hFFFF0000, 32'hC0DE0006, NOP};
        tbl[9]  = '{1'b0, 32'hFFFF000C, 32'h0,          16'h0000, 32'h4,        32'h0,        32'hC0DE0001};
        tbl[10] = '{1'b0, 32'hFFC,      32'h0,          16'h0000, 32'hFFC,      32'hC0DE03FF, 32'hC0DE03FF};

        // Reset state.
        step();
        step();
        check("rst_id", id, 32'h0);
        check("rst_mrd", mrd, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_bus_err", {31'd0, bus_err}, 32'h0);
        reset = 1'b0;
        edges = 0;

`ifdef MEM_RESPONDER_TIMER_IRQ_EN
        begin
            int e;
            drive(1'b1, BASE + 32'h4, 32'd5, 16'h000F, 32'h0);
            step();
            check("cmp_wr_irq", {31'd0, irq}, 32'h0);
            while (edges < 8) begin
                drive(1'b0, BASE, 32'h0, 16'h0, 32'h0);
                step();
                check($sformatf("cnt_e%0d", edges), mrd, 32'(edges - 1));
                check($sformatf("irq_e%0d", edges), {31'd0, irq}, {31'd0, edges >= 6});
            end
            drive(1'b0, BASE + 32'h8, 32'h0, 16'h0, 32'h0);
            step();
            check("status_pending", mrd, 32'h1);
            drive(1'b0, BASE + 32'h4, 32'h0, 16'h0, 32'h0);
            step();
            check("cmp_read", mrd, 32'd5);
            drive(1'b1, BASE + 32'h8, 32'h1, 16'h0001, 32'h0);
            step();
            check("clear_irq", {31'd0, irq}, 32'h0);
            check("clear_mrd_hold", mrd, 32'd5);
            drive(1'b0, BASE + 32'h8, 32'h0, 16'h0, 32'h0);
            step();
            check("status_cleared", mrd, 32'h0);
            drive(1'b1, BASE, 32'h0, 16'h000F, 32'h0);
            step();
            drive(1'b0, BASE, 32'h0, 16'h0, 32'h0);
            step();
            check("cnt_ro", mrd, 32'(edges - 1));
            drive(1'b1, BASE + 32'hC, 32'hFFFFFFFF, 16'h000F, 32'h0);
            step();
            drive(1'b0, BASE + 32'hC, 32'h0, 16'h0, 32'h0);
            step();
            check("reg_c_zero", mrd, 32'h0);
            check("reg_c_no_err", {31'd0, bus_err}, 32'h0);

            // Match and clear in the same cycle: the set wins.
            e = edges;
            drive(1'b1, BASE + 32'h4, 32'(e + 10), 16'h000F, 32'h0);
            step();
            while (edges < e + 10) begin
                drive(1'b0, BASE, 32'h0, 16'h0, 32'h0);
                step();
                check("pre_match_irq", {31'd0, irq}, 32'h0);
            end
            drive(1'b1, BASE + 32'h8, 32'h1, 16'h0001, 32'h0);
            step();
            check("set_wins_irq", {31'd0, irq}, 32'h1);
            drive(1'b0, BASE, 32'h0, 16'h0, 32'h0);
            step();
            check("set_wins_hold", {31'd0, irq}, 32'h1);
            drive(1'b1, BASE + 32'h8, 32'h1, 16'h0001, 32'h0);
            step();
            check("late_clear_irq", {31'd0, irq}, 32'h0);

            drive(1'b1, BASE + 32'h4, 32'h11223344, 16'h000F, 32'h0);
            step();
            drive(1'b1, BASE + 32'h4, 32'hAABBCCDD, 16'hFFF5, 32'h0);
            step();
            drive(1'b0, BASE + 32'h4, 32'h0, 16'h0, 32'h0);
            step();
            check("cmp_byte_en", mrd, 32'h11BB33DD);
        end
`else
        drive(1'b1, BASE + 32'h4, 32'hFFFFFFFF, 16'h000F, 32'h0);
        step();
        drive(1'b1, BASE + 32'h8, 32'hFFFFFFFF, 16'h000F, 32'h0);
        step();
        for (int r = 0; r < 4; r++) begin
            drive(1'b0, BASE + 32'(4 * r), 32'h0, 16'h0, 32'h0);
            step();
            check($sformatf("mmio_off_rd%0d", r), mrd, 32'h0);
            check($sformatf("mmio_off_irq%0d", r), {31'd0, irq}, 32'h0);
            check($sformatf("mmio_off_err%0d", r), {31'd0, bus_err}, 32'h0);
        end
`endif

        // Preload a window of RAM plus the last word so every later read has a known value.
        for (int i = 0; i < 65; i++) begin
            int w;
            w = (i == 64) ? DEPTH - 1 : i;
            drive(1'b1, 32'(w * 4), fill_val(w), 16'h000F, 32'h0);
            step();
            model_store(32'(w * 4), fill_val(w), 16'h000F);
        end
        drive(1'b0, 32'h0, 32'h0, 16'h0, 32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].ia);
            step();
            if (tbl[i].wr) model_store(tbl[i].addr, tbl[i].data, tbl[i].mask);
            check($sformatf("tbl%0d_mrd", i), mrd, tbl[i].exp_mrd);
            check($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
            check($sformatf("tbl%0d_bus_err", i), {31'd0, bus_err}, 32'h0);
        end
        exp_mrd = tbl[10].exp_mrd;

        for (int n = 0; n < 200; n++) begin
            logic        w;
            logic [31:0] a, d, fa, exp_id;
            logic [15:0] m;
            int          r;
            w = 1'($urandom_range(0, 1));
            a = rand_ram_addr();
            d = $urandom;
            m = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      fa = 32'h0000_1000 + ($urandom & 32'h0000_FFFF);
            else if (r == 1) fa = $urandom | 32'h8000_0000;
            else             fa = rand_ram_addr();
            exp_id = model_fetch(fa);
            if (!w) exp_mrd = model_mem[a / 4];
            drive(w, a, d, m, fa);
            step();
            if (w) model_store(a, d, m);
            check($sformatf("rnd%0d_mrd", n), mrd, exp_mrd);
            check($sformatf("rnd%0d_id", n), id, exp_id);
            check($sformatf("rnd%0d_bus_err", n), {31'd0, bus_err}, 32'h0);
        end

        // Out-of-range accesses: sticky error, zero data, stores dropped.
        drive(1'b0, 32'h8000_0000, 32'h0, 16'h0, 32'h0);
        step();
        check("miss_ld_mrd", mrd, 32'h0);
        check("miss_ld_err", {31'd0, bus_err}, 32'h1);
        drive(1'b1, 32'h8000_0010, 32'h12345678, 16'h000F, 32'h0);
        step();
        check("miss_st_mrd_hold", mrd, 32'h0);
        drive(1'b1, 32'h0000_1000, 32'h87654321, 16'h000F, 32'h0);
        step();
        drive(1'b0, 32'h10, 32'h0, 16'h0, 32'h0);
        step();
        check("miss_st_word4", mrd, model_mem[4]);
        check("miss_sticky1", {31'd0, bus_err}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 16'h0, 32'h0);
        step();
        check("miss_st_word0", mrd, model_mem[0]);
        check("miss_sticky2", {31'd0, bus_err}, 32'h1);

        // Reset in the middle of a store cycle.
        drive(1'b1, 32'h20, 32'hBAD0BAD0, 16'h000F, 32'h20);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_id", id, 32'h0);
        check("mid_rst_mrd", mrd, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        check("mid_rst_err", {31'd0, bus_err}, 32'h0);
        step();
        check("rst_edge_id", id, 32'h0);
        check("rst_edge_mrd", mrd, 32'h0);
        drive(1'b0, 32'h20, 32'h0, 16'h0, 32'h20);
        reset = 1'b0;
        edges = 0;
        step();
        check("post_rst_mrd", mrd, model_mem[8]);
        check("post_rst_id", id, model_mem[8]);
        check("post_rst_err", {31'd0, bus_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit RAM words, power of two, 16..65536.
REQ-002 Parameter: MMIO_BASE, 32'hFFFF_0000, base address of the timer/IRQ register page.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: ia  input  32  instruction fetch byte address.
REQ-006 Port: id  output  32  fetched instruction word, registered.
REQ-007 Port: addr_in  input  32  data access byte address.
REQ-008 Port: data_in  input  32  store data.
REQ-009 Port: wr  input  1  store strobe; 0 means the cycle is a load.
REQ-010 Port: wr_mask  input  16  byte enables; bits [3:0] select bytes 0..3; bits [15:4] ignored.
REQ-011 Port: mrd  output  32  load data, registered.
REQ-012 Port: irq  output  1  timer interrupt request, level, registered.
REQ-013 Port: bus_err  output  1  sticky flag for an access outside RAM and the MMIO page.

Function
REQ-014 Address bits [1:0] SHALL be ignored for both ports; word index = addr[31:2].
REQ-015 RAM hit SHALL be addr < DEPTH_WORDS*4; MMIO hit SHALL be addr[31:4] == MMIO_BASE[31:4].
REQ-016 id SHALL equal RAM[ia] one cycle after ia is presented; a non-RAM ia SHALL return 32'h0000_0013 (NOP).
REQ-017 When wr=0: mrd SHALL equal the addressed word one cycle later; a miss SHALL return 0 and set bus_err.
REQ-018 When wr=1 and RAM hit: each byte lane i with wr_mask[i]=1 SHALL be written at the clock edge; other lanes are unchanged.
REQ-019 When wr=1: mrd SHALL hold its previous value; a miss SHALL drop the write and set bus_err.
REQ-020 Same-cycle data write and instruction fetch to one word: id SHALL return the old (pre-write) word.
REQ-021 A load in the cycle after a store to the same word SHALL return the new data.
REQ-022 MMIO+0x0 TIMER_CNT is read-only; writes are ignored. It increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
REQ-023 MMIO+0x4 TIMER_CMP is read/write and honours byte enables.
REQ-024 MMIO+0x8 IRQ_STATUS: bit0 = pending; writing 1 to bit0 (lane 0 enabled) clears it; other bits read 0.
REQ-025 MMIO+0xC SHALL read 0, ignore writes, and not set bus_err.
REQ-026 Pending SHALL be set at the edge where TIMER_CNT == TIMER_CMP and TIMER_CMP != 0; irq = pending.
REQ-027 If compare match and clear occur in the same cycle, set SHALL win (pending stays 1).
REQ-028 bus_err SHALL clear only on reset.

Reset
REQ-029 While reset=1: id=0, mrd=0, irq=0, bus_err=0, TIMER_CNT=0, TIMER_CMP=0, pending=0; no RAM writes occur.
REQ-030 RAM contents SHALL NOT be cleared by reset; a mid-cycle reset SHALL discard any pending store.
REQ-031 The first access is served at the first rising edge after reset deasserts.

Configuration
REQ-032 Macro MEM_RESPONDER_TIMER_IRQ_EN: when defined, REQ-022..REQ-027 apply.
REQ-033 Without MEM_RESPONDER_TIMER_IRQ_EN: the MMIO page reads 0 and ignores writes without setting bus_err; irq is tied 0; no timer registers are synthesized.

Verification
REQ-034 Store 32'hDEADBEEF to 0x10 with mask 4'hF, then load 0x10 -> mrd=32'hDEADBEEF one cycle after the load.
REQ-035 Store 32'h000000AA to 0x10 with mask 4'h1 over DEADBEEF, then load -> mrd=32'hDEADBEAA.
REQ-036 Write TIMER_CMP=5 right after reset -> irq rises when TIMER_CNT reaches 5; write 1 to IRQ_STATUS -> irq=0 next cycle.
REQ-037 Clear IRQ_STATUS in the same cycle as a compare match -> irq remains 1.
REQ-038 Load 0x8000_0000 -> mrd=0 and bus_err=1; bus_err stays 1 until reset, and RAM is unchanged.
REQ-039 Assert reset mid-store to 0x20 -> word at 0x20 unchanged; id=0 and mrd=0 while reset=1.
